// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, command codes and default timing for the LCD nibble writer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_EXEC  = 3'd5
  } lcd_wr_state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Default timing in cycles at 200 MHz; also used by the top_lcd sequencer.
  localparam int T_SETUP_CYC_DEF = 20;
  localparam int T_EHIGH_CYC_DEF = 60;
  localparam int T_HOLD_CYC_DEF  = 20;
  localparam int T_GAP_CYC_DEF   = 200;
  localparam int T_EXEC_CYC_DEF  = 8000;
  localparam int T_CLEAR_CYC_DEF = 330000;

  // Clear and Home need the long controller execution time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable down-counter flagging when it reaches zero
module lcd_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Load on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - HD44780 4-bit bus writer: one byte per handshake, two timed nibbles
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = T_SETUP_CYC_DEF,
  parameter int T_EHIGH_CYC = T_EHIGH_CYC_DEF,
  parameter int T_HOLD_CYC  = T_HOLD_CYC_DEF,
  parameter int T_GAP_CYC   = T_GAP_CYC_DEF,
  parameter int T_EXEC_CYC  = T_EXEC_CYC_DEF,
  parameter int T_CLEAR_CYC = T_CLEAR_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_rs,
  input  logic [7:0] s_data,
  input  logic       s_nibble_only,
  output logic       busy,
  output logic [3:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  localparam int T_MAX = max_of(max_of(max_of(T_SETUP_CYC, T_EHIGH_CYC), max_of(T_HOLD_CYC, T_GAP_CYC)),
                                max_of(T_EXEC_CYC, T_CLEAR_CYC));
  localparam int CW = $clog2(T_MAX) + 1;

  // Counters are loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EHIGH = CW'(T_EHIGH_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR_CYC - 1);

  lcd_wr_state_t state;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          low_pending;
  logic          accept;
  logic          slow;
  logic          cnt_load;
  logic [CW-1:0] cnt_value;
  logic          cnt_done;

  assign accept = s_valid && s_ready;
  assign slow   = is_slow_cmd(rs_q, data_q);

  lcd_delay_counter #(.W(CW)) u_delay (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .done  (cnt_done)
  );

  // Reload the delay counter with the duration of whichever timed state comes next.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load  = 1'b1;
          cnt_value = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = LD_EHIGH;
        end
      end
      ST_EHIGH: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = low_pending ? LD_GAP : (slow ? LD_CLEAR : LD_EXEC);
        end
      end
      ST_GAP: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = LD_SETUP;
        end
      end
      default: begin
        cnt_load  = 1'b0;
        cnt_value = '0;
      end
    endcase
  end

  // Sequencer: accept a byte, strobe one or two nibbles, then wait out the execution time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      lcd_data    <= 4'h0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      low_pending <= 1'b0;
    end else begin
      lcd_rw <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rs_q        <= s_rs;
            data_q      <= s_data;
            low_pending <= !s_nibble_only;
            lcd_rs      <= s_rs;
            lcd_data    <= s_data[7:4];
            lcd_e       <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_SETUP;
          end else begin
            s_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            lcd_e <= 1'b1;
            state <= ST_EHIGH;
          end
        end
        ST_EHIGH: begin
          if (cnt_done) begin
            lcd_e <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            if (low_pending) begin
              low_pending <= 1'b0;
              state       <= ST_GAP;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_GAP: begin
          if (cnt_done) begin
            lcd_data <= data_q[3:0];
            state    <= ST_SETUP;
          end
        end
        ST_EXEC: begin
          if (cnt_done) begin
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Low-level HD44780 bus driver for the VC707 character LCD; it sits directly under top_lcd's message/init sequencer.
- Accepts one command or data byte per valid/ready handshake.
- Drives it onto the 4-bit LCD bus as two timed nibble writes (high then low), or one write in nibble-only mode.
- Then waits the controller execution time before accepting the next byte.

Parameters:
- T_SETUP_CYC, 20, cycles lcd_rs/lcd_data are stable before lcd_e rises (100 ns at 200 MHz).
- T_EHIGH_CYC, 60, cycles lcd_e is high (300 ns).
- T_HOLD_CYC, 20, cycles lcd_data/lcd_rs are held after lcd_e falls.
- T_GAP_CYC, 200, idle cycles between high and low nibble (1 us).
- T_EXEC_CYC, 8000, post-byte wait for normal commands/data (40 us).
- T_CLEAR_CYC, 330000, post-byte wait for Clear (0x01) and Home (0x02) commands (1.65 ms).

Ports:
- clk  in  1  system clock, 200 MHz.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  byte request valid.
- s_ready  out  1  block can accept a byte.
- s_rs  in  1  0 = command, 1 = data.
- s_data  in  8  byte to write.
- s_nibble_only  in  1  send only s_data[7:4] (init 0x3/0x2 writes).
- busy  out  1  transfer or execution wait in progress.
- lcd_data  out  4  LCD DB7..DB4.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write, held 0 (write only).

Behaviour:
- Reset (rst low, asynchronous): state IDLE; s_ready=0; busy=0; lcd_data=0; lcd_e=0; lcd_rs=0; lcd_rw=0.
- s_ready rises on the first clk edge after reset release.
- All outputs are registered.
- Handshake:
  - A transfer is accepted on an edge where s_valid && s_ready.
  - s_rs, s_data and s_nibble_only are latched; s_ready falls and busy rises on that same edge.
  - s_valid without s_ready is ignored. Inputs are don't-care outside acceptance.
- FSM states: IDLE, SETUP, EHIGH, HOLD, GAP, EXEC. Each timed state lasts exactly its parameter count in cycles; every parameter is >=1.
- IDLE -> SETUP on accept:
  - lcd_rs = latched rs; lcd_data = latched data[7:4]; lcd_e = 0.
- SETUP -> EHIGH: lcd_e = 1; data and rs unchanged.
- EHIGH -> HOLD: lcd_e = 0; data and rs unchanged.
- HOLD -> GAP if the low nibble is still pending (not nibble-only, first nibble just sent).
- HOLD -> EXEC otherwise.
- GAP -> SETUP:
  - lcd_data = latched data[3:0] on entry to the second SETUP.
  - During GAP, lcd_data and lcd_rs keep their prior values.
- EXEC wait length:
  - T_CLEAR_CYC if rs=0 and data in {0x01, 0x02}.
  - T_CLEAR_CYC also applies in nibble-only mode under the same test.
  - T_EXEC_CYC otherwise.
- EXEC -> IDLE: s_ready=1 and busy=0 on the same edge.
  - Earliest next accept is the edge after that, so there are no back-to-back transfers without at least one ready cycle.
- Busy period from accept edge to ready-high edge:
  - Full byte: 2*(S+E+H)+G+X cycles. Defaults: 8400, or 330400 for clear/home.
  - Nibble-only: (S+E+H)+X cycles. Default: 8100.
- lcd_e pulses exactly once per nibble and never while lcd_data or lcd_rs changes.
- Reset mid-transfer: the transfer is abandoned and all outputs return to reset values immediately. No partial resume.
- Counter: a single down-counter sized to clog2(max parameter)+1 bits.
  - Loaded with N-1 on state entry; the state exits when it reads 0.
  - No wrap-around is possible.

Decomposition:
- Package lcd_pkg holds:
  - state enum lcd_wr_state_t.
  - constants CMD_CLEAR=8'h01 and CMD_HOME=8'h02.
  - default timing constants in cycles at 200 MHz, shared with the top_lcd sequencer.
- One sub-module is natural: lcd_delay_counter, a loadable down-counter with a load input, a count value, and a done flag when zero. It is used for every timed state.

Test Plan:
- Reset release: hold rst low for 20 us -> all LCD outputs 0, s_ready=0; s_ready=1 on the first edge after release.
- Data write: s_rs=1, s_data=8'h41 ->
  - lcd_data=4'h4 with lcd_rs=1; lcd_e high for exactly 60 cycles after 20 setup cycles.
  - 200-cycle gap, then lcd_data=4'h1 with the same E timing.
  - s_ready returns exactly 8400 cycles after accept.
- Clear command: s_rs=0, s_data=8'h01 -> nibbles 0 then 1 with lcd_rs=0; s_ready returns after 330400 cycles.
- Nibble-only init: s_nibble_only=1, s_data=8'h30, s_rs=0 -> a single E pulse with lcd_data=4'h3; s_ready returns after 8100 cycles.
- Handshake stress: hold s_valid=1 continuously with changing s_data during busy -> only bytes present on ready edges are transferred, one E-pulse pair each; lcd_rw stays 0 throughout.
- Reset mid-transfer: drop rst during EHIGH of the first nibble -> lcd_e=0 and lcd_data=0 with no clock edge; after release, a fresh 8'h48 write completes normally.
